// File: rtl/read_control_pkg.sv
// ---------------------------------------------------------------------------
// read_control_pkg
// Shared FIFO defaults used by both the read and write control blocks.
// Ports: none (package).
//   ADD_WIDTH_DEF  : RAM address width; pointers carry one extra wrap bit.
//   AEMPTY_TH_DEF  : almost-empty threshold in words.
// ---------------------------------------------------------------------------
package read_control_pkg;

   localparam int ADD_WIDTH_DEF = 9;
   localparam int AEMPTY_TH_DEF = 4;

endpackage : read_control_pkg

// File: rtl/read_control_if.sv
// ---------------------------------------------------------------------------
// read_control_if
// Groups the read-side consumer handshake, status flags and pointer bus.
// Ports (signals):
//   r_req_i        raw read request from the consumer
//   w_g_addr       write-side Gray pointer (asynchronous to the read clock)
//   r_req_o        qualified RAM read enable
//   r_empty_o      empty flag
//   r_aempty_o     almost-empty flag
//   r_valid_o      RAM read data valid
//   r_underflow_o  sticky underflow error
//   r_level_o      fill level seen from the read side
//   r_addr_bin     binary read pointer (RAM uses the low ADD_WIDTH bits)
//   r_addr_gray    Gray read pointer towards the write side
// Modports: master = consumer/write side, slave = read_control.
// ---------------------------------------------------------------------------
interface read_control_if #(
   parameter int ADD_WIDTH = read_control_pkg::ADD_WIDTH_DEF
);

   logic                 r_req_i;
   logic [ADD_WIDTH:0]   w_g_addr;
   logic                 r_req_o;
   logic                 r_empty_o;
   logic                 r_aempty_o;
   logic                 r_valid_o;
   logic                 r_underflow_o;
   logic [ADD_WIDTH:0]   r_level_o;
   logic [ADD_WIDTH:0]   r_addr_bin;
   logic [ADD_WIDTH:0]   r_addr_gray;

   modport master (
      output r_req_i, w_g_addr,
      input  r_req_o, r_empty_o, r_aempty_o, r_valid_o, r_underflow_o,
             r_level_o, r_addr_bin, r_addr_gray
   );

   modport slave (
      input  r_req_i, w_g_addr,
      output r_req_o, r_empty_o, r_aempty_o, r_valid_o, r_underflow_o,
             r_level_o, r_addr_bin, r_addr_gray
   );

endinterface : read_control_if

// File: rtl/read_control_bin_to_gray.sv
// ---------------------------------------------------------------------------
// bin_to_gray
// Combinational binary-to-Gray converter, shared across the FIFO blocks.
// Ports:
//   bin   binary input  (WIDTH bits)
//   gray  Gray output   (WIDTH bits)
// ---------------------------------------------------------------------------
module bin_to_gray #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = (bin >> 1) ^ bin;

endmodule : bin_to_gray

// File: rtl/read_control_gray_sync.sv
// ---------------------------------------------------------------------------
// gray_sync
// Two-stage synchronizer for a Gray-coded pointer crossing clock domains.
// Used on both FIFO sides (write pointer into read domain and vice versa).
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears both stages
//   d      Gray pointer from the other domain
//   q      synchronized pointer, two destination edges late
// ---------------------------------------------------------------------------
module gray_sync #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage1;

   // Only one bit of a Gray pointer changes per increment, so a
   // metastable capture resolves to either the old or the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1 <= '0;
         q      <= '0;
      end else begin
         stage1 <= d;
         q      <= stage1;
      end
   end

endmodule : gray_sync

// File: rtl/read_control.sv
// ---------------------------------------------------------------------------
// read_control
// Read-side control of an asynchronous FIFO: qualifies read requests,
// advances the read pointer, and derives empty/almost-empty/level from the
// synchronized write pointer.
// Ports:
//   r_clk_i  read clock (only clock of the block)
//   rst_n_i  asynchronous active-low reset
//   rd       read_control_if.slave bundle (request, flags, pointers)
// Parameters:
//   ADD_WIDTH  RAM address width (pointers are ADD_WIDTH+1 bits)
//   AEMPTY_TH  almost-empty threshold in words
// ---------------------------------------------------------------------------
module read_control
   import read_control_pkg::*;
#(
   parameter int ADD_WIDTH = ADD_WIDTH_DEF,
   parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
   input  logic           r_clk_i,
   input  logic           rst_n_i,
   read_control_if.slave  rd
);

   localparam int            W          = ADD_WIDTH + 1;
   localparam logic [W-1:0]  AEMPTY_LIM = W'(AEMPTY_TH);

   logic [W-1:0] w_g_sync;
   logic [W-1:0] w_b_sync;
   logic [W-1:0] r_addr_bin_q;
   logic [W-1:0] r_addr_gray_w;
   logic [W-1:0] r_level;
   logic         r_empty;
   logic         r_req;
   logic         r_valid_q;
   logic         r_underflow_q;

   gray_sync #(.WIDTH(W)) u_w_sync (
      .clk   (r_clk_i),
      .rst_n (rst_n_i),
      .d     (rd.w_g_addr),
      .q     (w_g_sync)
   );

   bin_to_gray #(.WIDTH(W)) u_bin_to_gray (
      .bin  (r_addr_bin_q),
      .gray (r_addr_gray_w)
   );

   // Empty compares in the Gray domain so no conversion sits on this path;
   // it is pessimistic because w_g_sync lags the real write pointer.
   assign r_empty = (r_addr_gray_w == w_g_sync);
   assign r_req   = rd.r_req_i & ~r_empty;

   // Gray to binary: bit i is the XOR of all bits from the MSB down to i.
   always_comb begin
      w_b_sync = '0;
      for (int i = 0; i < W; i++) begin
         w_b_sync[i] = ^(w_g_sync >> i);
      end
   end

   assign r_level = w_b_sync - r_addr_bin_q;

   // Pointer advances only on qualified reads; valid is the read enable
   // delayed by the RAM's one-cycle latency; underflow is sticky.
   always_ff @(posedge r_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_addr_bin_q  <= '0;
         r_valid_q     <= 1'b0;
         r_underflow_q <= 1'b0;
      end else begin
         if (r_req) begin
            r_addr_bin_q <= r_addr_bin_q + 1'b1;
         end
         r_valid_q <= r_req;
         if (rd.r_req_i && r_empty) begin
            r_underflow_q <= 1'b1;
         end
      end
   end

   assign rd.r_req_o       = r_req;
   assign rd.r_empty_o     = r_empty;
   assign rd.r_aempty_o    = (r_level <= AEMPTY_LIM);
   assign rd.r_valid_o     = r_valid_q;
   assign rd.r_underflow_o = r_underflow_q;
   assign rd.r_level_o     = r_level;
   assign rd.r_addr_bin    = r_addr_bin_q;
   assign rd.r_addr_gray   = r_addr_gray_w;

endmodule : read_control

// File: tb/tb_read_control.sv
// ---------------------------------------------------------------------------
// tb_read_control
// Self-checking bench for read_control. A word-count model (read count,
// delayed copies of the write count) predicts every output each cycle;
// directed sequences pin the model with literal expectations, then a
// randomized read/write phase runs against the same model.
// ---------------------------------------------------------------------------
module tb_read_control;

   localparam int AW  = 9;
   localparam int W   = AW + 1;
   localparam int TH  = 4;
   localparam int MOD = 1 << W;

   logic r_clk_i = 1'b0;
   logic rst_n_i = 1'b0;

   int check_count = 0;
   int error_count = 0;
   int w_bin       = 0;

   read_control_if #(.ADD_WIDTH(AW)) rd_if ();

   read_control #(.ADD_WIDTH(AW), .AEMPTY_TH(TH)) dut (
      .r_clk_i (r_clk_i),
      .rst_n_i (rst_n_i),
      .rd      (rd_if.slave)
   );

   always #5 r_clk_i = ~r_clk_i;

   // Reference model in word counts: m_rd = words consumed, m_s1/m_s2 =
   // write count as seen one and two read edges later.
   int   m_rd, m_s1, m_s2;
   logic m_valid, m_uf;

   always @(posedge r_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_rd    <= 0;
         m_s1    <= 0;
         m_s2    <= 0;
         m_valid <= 1'b0;
         m_uf    <= 1'b0;
      end else begin
         m_uf    <= m_uf | (rd_if.r_req_i && (m_rd == m_s2));
         m_valid <= rd_if.r_req_i && (m_rd != m_s2);
         if (rd_if.r_req_i && (m_rd != m_s2)) m_rd <= (m_rd + 1) % MOD;
         m_s2 <= m_s1;
         m_s1 <= w_bin;
      end
   end

   function automatic logic [W-1:0] to_gray(input int b);
      int v;
      v = b % MOD;
      return W'(v ^ (v >> 1));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      check_count++;
      if (act !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic req, input int wb);
      rd_if.r_req_i  = req;
      w_bin          = wb % MOD;
      rd_if.w_g_addr = to_gray(w_bin);
   endtask

   task automatic step();
      @(posedge r_clk_i);
      #1;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge r_clk_i) begin : cmp
      logic exp_empty;
      int   exp_level;
      exp_empty = (m_rd == m_s2);
      exp_level = (m_s2 - m_rd + MOD) % MOD;
      checkOutput("model r_empty_o",     rd_if.r_empty_o,     exp_empty);
      checkOutput("model r_req_o",       rd_if.r_req_o,       rd_if.r_req_i && !exp_empty);
      checkOutput("model r_level_o",     rd_if.r_level_o,     exp_level);
      checkOutput("model r_aempty_o",    rd_if.r_aempty_o,    exp_level <= TH);
      checkOutput("model r_addr_bin",    rd_if.r_addr_bin,    m_rd);
      checkOutput("model r_addr_gray",   rd_if.r_addr_gray,   m_rd ^ (m_rd >> 1));
      checkOutput("model r_valid_o",     rd_if.r_valid_o,     m_valid);
      checkOutput("model r_underflow_o", rd_if.r_underflow_o, m_uf);
   end

   initial begin
      logic rq;
      int   wb;
      applyStimulus(1'b0, 0);
      rst_n_i = 1'b0;
      repeat (3) step();

      // Reset state with w_g_addr = 0
      @(negedge r_clk_i);
      checkOutput("reset empty",  rd_if.r_empty_o,     1);
      checkOutput("reset aempty", rd_if.r_aempty_o,    1);
      checkOutput("reset level",  rd_if.r_level_o,     0);
      checkOutput("reset gray",   rd_if.r_addr_gray,   0);
      checkOutput("reset uf",     rd_if.r_underflow_o, 0);
      step();
      rst_n_i = 1'b1;
      applyStimulus(1'b1, 0);
      @(negedge r_clk_i);
      checkOutput("blocked req_o", rd_if.r_req_o, 0);
      step();
      applyStimulus(1'b0, 0);
      @(negedge r_clk_i);
      checkOutput("underflow set", rd_if.r_underflow_o, 1);
      checkOutput("blocked no valid", rd_if.r_valid_o, 0);
      checkOutput("blocked no move", rd_if.r_addr_bin, 0);

      // Reset clears the sticky underflow
      step();
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      @(negedge r_clk_i);
      checkOutput("underflow cleared", rd_if.r_underflow_o, 0);

      // Write pointer jumps to gray(3): empty falls on the 2nd edge
      step();
      applyStimulus(1'b0, 3);
      step();
      @(negedge r_clk_i);
      checkOutput("sync edge1 empty", rd_if.r_empty_o, 1);
      step();
      @(negedge r_clk_i);
      checkOutput("sync edge2 empty", rd_if.r_empty_o, 0);
      checkOutput("sync edge2 level", rd_if.r_level_o, 3);
      checkOutput("pre-burst valid", rd_if.r_valid_o, 0);

      // Three back-to-back reads
      step();
      applyStimulus(1'b1, 3);
      for (int k = 1; k <= 3; k++) begin
         step();
         if (k == 3) applyStimulus(1'b0, 3);
         @(negedge r_clk_i);
         checkOutput("burst addr", rd_if.r_addr_bin, k);
         checkOutput("burst valid", rd_if.r_valid_o, 1);
      end
      checkOutput("burst end empty", rd_if.r_empty_o, 1);
      step();
      @(negedge r_clk_i);
      checkOutput("burst valid drop", rd_if.r_valid_o, 0);
      checkOutput("burst addr hold", rd_if.r_addr_bin, 3);
      checkOutput("burst no underflow", rd_if.r_underflow_o, 0);

      // Almost-empty walk from level 10 down to 0
      step();
      applyStimulus(1'b0, 13);
      step();
      step();
      for (int lvl = 10; lvl >= 0; lvl--) begin
         @(negedge r_clk_i);
         checkOutput("walk level",  rd_if.r_level_o,  lvl);
         checkOutput("walk aempty", rd_if.r_aempty_o, lvl <= 4);
         checkOutput("walk empty",  rd_if.r_empty_o,  lvl == 0);
         if (lvl > 0) begin
            step();
            applyStimulus(1'b1, 13);
            step();
            applyStimulus(1'b0, 13);
         end
      end

      // Full: 2^AW words visible with the read pointer at 0
      step();
      rst_n_i = 1'b0;
      applyStimulus(1'b0, 512);
      step();
      rst_n_i = 1'b1;
      step();
      step();
      @(negedge r_clk_i);
      checkOutput("full level",  rd_if.r_level_o,  512);
      checkOutput("full empty",  rd_if.r_empty_o,  0);
      checkOutput("full aempty", rd_if.r_aempty_o, 0);

      // Drain 511 words, then cross the pointer wrap bit
      step();
      applyStimulus(1'b1, 512);
      for (int i = 0; i < 511; i++) step();
      applyStimulus(1'b0, 512);
      @(negedge r_clk_i);
      checkOutput("pre-wrap addr",  rd_if.r_addr_bin, 511);
      checkOutput("pre-wrap level", rd_if.r_level_o,  1);
      step();
      applyStimulus(1'b0, 513);
      step();
      step();
      @(negedge r_clk_i);
      checkOutput("wrap level", rd_if.r_level_o, 2);
      step();
      applyStimulus(1'b1, 513);
      step();
      @(negedge r_clk_i);
      checkOutput("wrap addr 512",  rd_if.r_addr_bin, 512);
      checkOutput("wrap ram addr",  rd_if.r_addr_bin[AW-1:0], 0);
      checkOutput("wrap gray msb",  rd_if.r_addr_gray[AW], 1);
      step();
      applyStimulus(1'b0, 513);
      @(negedge r_clk_i);
      checkOutput("wrap addr 513", rd_if.r_addr_bin, 513);
      checkOutput("wrap gray 513", rd_if.r_addr_gray, 10'd769);
      checkOutput("wrap empty",    rd_if.r_empty_o,   1);

      // Reset asserted in the middle of a burst
      step();
      applyStimulus(1'b0, 520);
      step();
      step();
      step();
      applyStimulus(1'b1, 520);
      step();
      step();
      rst_n_i = 1'b0;
      applyStimulus(1'b1, 0);
      #1;
      checkOutput("midrst valid",  rd_if.r_valid_o,   0);
      checkOutput("midrst addr",   rd_if.r_addr_bin,  0);
      checkOutput("midrst gray",   rd_if.r_addr_gray, 0);
      checkOutput("midrst empty",  rd_if.r_empty_o,   1);
      checkOutput("midrst aempty", rd_if.r_aempty_o,  1);
      checkOutput("midrst level",  rd_if.r_level_o,   0);
      checkOutput("midrst req_o",  rd_if.r_req_o,     0);
      step();
      rst_n_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge r_clk_i);
         checkOutput("post-rst valid", rd_if.r_valid_o,  0);
         checkOutput("post-rst addr",  rd_if.r_addr_bin, 0);
      end
      applyStimulus(1'b0, 0);

      // Randomized phase with periodic resets; windows alternate between
      // draining and filling so both empty and full regions are exercised.
      step();
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         if ((c % 600) == 599) begin
            rst_n_i = 1'b0;
            applyStimulus(1'b0, 0);
            step();
            rst_n_i = 1'b1;
         end else begin
            if (((c / 600) % 2) == 0) rq = ($urandom_range(0, 3) != 0);
            else                      rq = ($urandom_range(0, 3) == 0);
            wb = w_bin;
            if (($urandom_range(0, 2) != 0) && (((w_bin - m_rd + MOD) % MOD) < 512))
               wb = w_bin + 1;
            applyStimulus(rq, wb);
         end
      end

      applyStimulus(1'b0, w_bin);
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule : tb_read_control
